// File: rtl/regfile_2r1w_pkg.sv
// Shared definitions for the 2-read/1-write register file: sizing, the zero
// register address and the read-source priority used by both data and busy paths.
package regfile_2r1w_pkg;

    localparam int ZERO_ADDR = 0;

    // Where a read port takes its value from, after applying the override rules.
    typedef enum logic [1:0] {
        SRC_ARRAY  = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_ZERO   = 2'd2
    } rd_src_e;

    function automatic int nregs_of(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    // Zero register beats bypass, bypass beats the stored value.
    function automatic rd_src_e resolve_src(
        input logic zero_en,
        input logic bypass_en,
        input logic is_zero_addr,
        input logic write_hit
    );
        if (zero_en && is_zero_addr) begin
            return SRC_ZERO;
        end
        if (bypass_en && write_hit) begin
            return SRC_BYPASS;
        end
        return SRC_ARRAY;
    endfunction

endpackage

// File: rtl/regfile_2r1w_scoreboard.sv
// Per-register pending-write scoreboard: issue sets, writeback clears (set wins
// on a same-address collision), with two masked busy read ports.
module regfile_2r1w_scoreboard
    import regfile_2r1w_pkg::*;
#(
    parameter int ADDR_BITS = 4,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic                 set_busy,
    input  logic [ADDR_BITS-1:0] busy_addr,
    input  logic [ADDR_BITS-1:0] raddr_a,
    input  logic [ADDR_BITS-1:0] raddr_b,
    output logic                 busy_a,
    output logic                 busy_b
);

    localparam int                   NREGS     = nregs_of(ADDR_BITS);
    localparam logic                 ZERO_EN   = (ZERO_REG != 0);
    localparam logic                 BYPASS_EN = (BYPASS != 0);
    localparam logic [ADDR_BITS-1:0] ZERO_A    = ADDR_BITS'(ZERO_ADDR);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    rd_src_e          src_a;
    rd_src_e          src_b;

    // Clear first, then set, so a new producer issued in the same cycle as the
    // old one retires keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        if (we) begin
            busy_d[waddr] = 1'b0;
        end
        if (set_busy && !(ZERO_EN && busy_addr == ZERO_A)) begin
            busy_d[busy_addr] = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments only; the next value
    // is built in always_comb so the flop process stays a plain register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Only the registered bits feed the outputs: no path from set_busy.
    always_comb begin
        src_a  = resolve_src(ZERO_EN, BYPASS_EN, raddr_a == ZERO_A, we && waddr == raddr_a);
        src_b  = resolve_src(ZERO_EN, BYPASS_EN, raddr_b == ZERO_A, we && waddr == raddr_b);
        busy_a = (src_a == SRC_ARRAY) ? busy_q[raddr_a] : 1'b0;
        busy_b = (src_b == SRC_ARRAY) ? busy_q[raddr_b] : 1'b0;
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised CPU register file: two combinational read ports, one synchronous
// write port, optional zero register, optional write-to-read bypass, busy scoreboard.
module regfile_2r1w
    import regfile_2r1w_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 4,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 set_busy,
    input  logic [ADDR_BITS-1:0] busy_addr,
    input  logic [ADDR_BITS-1:0] raddr_a,
    input  logic [ADDR_BITS-1:0] raddr_b,
    output logic [WIDTH-1:0]     rdata_a,
    output logic [WIDTH-1:0]     rdata_b,
    output logic                 busy_a,
    output logic                 busy_b
);

    localparam int                   NREGS     = nregs_of(ADDR_BITS);
    localparam logic                 ZERO_EN   = (ZERO_REG != 0);
    localparam logic                 BYPASS_EN = (BYPASS != 0);
    localparam logic [ADDR_BITS-1:0] ZERO_A    = ADDR_BITS'(ZERO_ADDR);

    logic [WIDTH-1:0] regs [NREGS];
    rd_src_e          src_a;
    rd_src_e          src_b;

    // NOTE: the array is reset because software relies on every register
    // reading 0 after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && !(ZERO_EN && waddr == ZERO_A)) begin
            regs[waddr] <= wdata;
        end
    end

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        src_a = resolve_src(ZERO_EN, BYPASS_EN, raddr_a == ZERO_A, we && waddr == raddr_a);
        src_b = resolve_src(ZERO_EN, BYPASS_EN, raddr_b == ZERO_A, we && waddr == raddr_b);

        unique case (src_a)
            SRC_ZERO:   rdata_a = '0;
            SRC_BYPASS: rdata_a = wdata;
            default:    rdata_a = regs[raddr_a];
        endcase

        unique case (src_b)
            SRC_ZERO:   rdata_b = '0;
            SRC_BYPASS: rdata_b = wdata;
            default:    rdata_b = regs[raddr_b];
        endcase
    end

    regfile_2r1w_scoreboard #(
        .ADDR_BITS (ADDR_BITS),
        .ZERO_REG  (ZERO_REG),
        .BYPASS    (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .set_busy  (set_busy),
        .busy_addr (busy_addr),
        .raddr_a   (raddr_a),
        .raddr_b   (raddr_b),
        .busy_a    (busy_a),
        .busy_b    (busy_b)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench: four register files (all ZERO_REG/BYPASS combinations)
// share one stimulus stream; directed table, hand sequences, then random traffic.
module tb_regfile_2r1w;

    localparam int WIDTH     = 32;
    localparam int ADDR_BITS = 4;
    localparam int NREGS     = 16;
    localparam int NCFG      = 4;

    typedef struct {
        bit                   we;
        logic [ADDR_BITS-1:0] waddr;
        logic [WIDTH-1:0]     wdata;
        bit                   sb;
        logic [ADDR_BITS-1:0] ba;
        logic [ADDR_BITS-1:0] ra;
        logic [ADDR_BITS-1:0] rb;
        logic [WIDTH-1:0]     xa;
        logic [WIDTH-1:0]     xb;
        bit                   ya;
        bit                   yb;
    } vec_t;

    logic                 clk;
    logic                 reset;
    logic                 we;
    logic [ADDR_BITS-1:0] waddr;
    logic [WIDTH-1:0]     wdata;
    logic                 set_busy;
    logic [ADDR_BITS-1:0] busy_addr;
    logic [ADDR_BITS-1:0] raddr_a;
    logic [ADDR_BITS-1:0] raddr_b;

    logic [NCFG-1:0][WIDTH-1:0] rda;
    logic [NCFG-1:0][WIDTH-1:0] rdb;
    logic [NCFG-1:0]            bza;
    logic [NCFG-1:0]            bzb;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: plain arrays per configuration.
    logic [WIDTH-1:0] m_mem  [NCFG][NREGS];
    bit               m_busy [NCFG][NREGS];

    vec_t vecs [12];

    // cfg 0: Z1 B1, cfg 1: Z1 B0, cfg 2: Z0 B1, cfg 3: Z0 B0
    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        regfile_2r1w #(
            .WIDTH     (WIDTH),
            .ADDR_BITS (ADDR_BITS),
            .ZERO_REG  ((g < 2) ? 1 : 0),
            .BYPASS    ((g % 2 == 0) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .we        (we),
            .waddr     (waddr),
            .wdata     (wdata),
            .set_busy  (set_busy),
            .busy_addr (busy_addr),
            .raddr_a   (raddr_a),
            .raddr_b   (raddr_b),
            .rdata_a   (rda[g]),
            .rdata_b   (rdb[g]),
            .busy_a    (bza[g]),
            .busy_b    (bzb[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic bit cfg_zero(input int c);
        return c < 2;
    endfunction

    function automatic bit cfg_byp(input int c);
        return (c % 2) == 0;
    endfunction

    task automatic check(input string name, input int cfg,
                         input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cfg%0d: got %h expected %h (t=%0t)", name, cfg, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCFG; c++) begin
            for (int r = 0; r < NREGS; r++) begin
                m_mem[c][r]  = '0;
                m_busy[c][r] = 1'b0;
            end
        end
    endtask

    // Applies the clock-edge rules to the model using the current inputs.
    task automatic model_clock();
        for (int c = 0; c < NCFG; c++) begin
            if (we && !(cfg_zero(c) && waddr == 0)) m_mem[c][waddr] = wdata;
            if (we) m_busy[c][waddr] = 1'b0;
            if (set_busy && !(cfg_zero(c) && busy_addr == 0)) m_busy[c][busy_addr] = 1'b1;
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_rd(input int c, input logic [ADDR_BITS-1:0] ra);
        if (cfg_zero(c) && ra == 0) return '0;
        if (cfg_byp(c) && we && waddr == ra) return wdata;
        return m_mem[c][ra];
    endfunction

    function automatic logic [WIDTH-1:0] exp_bz(input int c, input logic [ADDR_BITS-1:0] ra);
        if (cfg_zero(c) && ra == 0) return '0;
        if (cfg_byp(c) && we && waddr == ra) return '0;
        return WIDTH'(m_busy[c][ra]);
    endfunction

    task automatic check_all();
        for (int c = 0; c < NCFG; c++) begin
            check("model_rdata_a", c, rda[c], exp_rd(c, raddr_a));
            check("model_rdata_b", c, rdb[c], exp_rd(c, raddr_b));
            check("model_busy_a", c, WIDTH'(bza[c]), exp_bz(c, raddr_a));
            check("model_busy_b", c, WIDTH'(bzb[c]), exp_bz(c, raddr_b));
        end
    endtask

    // Inputs are set just after a falling edge; check, clock, return at next falling edge.
    task automatic cycle();
        #1 check_all();
        @(posedge clk);
        if (reset) model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;
        set_busy  = 1'b0;
        busy_addr = '0;
    endtask

    initial begin
        idle();
        raddr_a = 4'd3;
        raddr_b = 4'd7;
        reset   = 1'b0;
        model_reset();

        // Reset state
        #12;
        for (int c = 0; c < NCFG; c++) begin
            check("reset_rdata_a", c, rda[c], '0);
            check("reset_rdata_b", c, rdb[c], '0);
            check("reset_busy_a", c, WIDTH'(bza[c]), '0);
            check("reset_busy_b", c, WIDTH'(bzb[c]), '0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Reset asserted mid-cycle while a write is pending discards the write.
        we      = 1'b1;
        waddr   = 4'd3;
        wdata   = 32'hCAFE_F00D;
        raddr_a = 4'd3;
        #2 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        for (int c = 0; c < NCFG; c++) check("midreset_rdata_a", c, rda[c], '0);
        reset = 1'b1;
        model_reset();
        cycle();
        for (int c = 0; c < NCFG; c++) check("after_midreset_rdata_a", c, rda[c], '0);

        // Bypass vs. no bypass on a write to the read address.
        we      = 1'b1;
        waddr   = 4'd5;
        wdata   = 32'hDEAD_BEEF;
        raddr_a = 4'd5;
        #1;
        check("bypass_same_cycle", 0, rda[0], 32'hDEAD_BEEF);
        check("nobypass_same_cycle", 1, rda[1], 32'h0);
        cycle();
        idle();
        #1;
        check("nobypass_next_cycle", 1, rda[1], 32'hDEAD_BEEF);

        @(negedge clk);
        reset = 1'b0;
        #1 reset = 1'b1;
        model_reset();

        // Directed table for cfg 0 (ZERO_REG=1, BYPASS=1), starting from reset.
        //           we  waddr wdata          sb  ba    ra    rb    xa             xb            ya  yb
        vecs[0]  = '{0, 4'd0, 32'h0,         1, 4'd9, 4'd5, 4'd9, 32'h0,         32'h0,        0,  0};
        vecs[1]  = '{1, 4'd5, 32'hDEADBEEF,  0, 4'd0, 4'd5, 4'd9, 32'hDEADBEEF,  32'h0,        0,  1};
        vecs[2]  = '{1, 4'd9, 32'hA5,        0, 4'd0, 4'd5, 4'd9, 32'hDEADBEEF,  32'hA5,       0,  0};
        vecs[3]  = '{0, 4'd0, 32'h0,         0, 4'd0, 4'd5, 4'd9, 32'hDEADBEEF,  32'hA5,       0,  0};
        vecs[4]  = '{1, 4'd0, 32'h12345678,  1, 4'd0, 4'd0, 4'd0, 32'h0,         32'h0,        0,  0};
        vecs[5]  = '{0, 4'd0, 32'h0,         0, 4'd0, 4'd0, 4'd0, 32'h0,         32'h0,        0,  0};
        vecs[6]  = '{1, 4'd4, 32'h44,        1, 4'd4, 4'd4, 4'd3, 32'h44,        32'h0,        0,  0};
        vecs[7]  = '{1, 4'd6, 32'h66,        1, 4'd2, 4'd4, 4'd2, 32'h44,        32'h0,        1,  0};
        vecs[8]  = '{0, 4'd0, 32'h0,         0, 4'd0, 4'd2, 4'd6, 32'h0,         32'h66,       1,  0};
        vecs[9]  = '{0, 4'd0, 32'h0,         1, 4'd2, 4'd2, 4'd6, 32'h0,         32'h66,       1,  0};
        vecs[10] = '{1, 4'd6, 32'h77,        0, 4'd0, 4'd6, 4'd2, 32'h77,        32'h0,        0,  1};
        vecs[11] = '{0, 4'd0, 32'h0,         0, 4'd0, 4'd6, 4'd6, 32'h77,        32'h77,       0,  0};

        for (int i = 0; i < 12; i++) begin
            we        = vecs[i].we;
            waddr     = vecs[i].waddr;
            wdata     = vecs[i].wdata;
            set_busy  = vecs[i].sb;
            busy_addr = vecs[i].ba;
            raddr_a   = vecs[i].ra;
            raddr_b   = vecs[i].rb;
            #1;
            check($sformatf("vec%0d_rdata_a", i), 0, rda[0], vecs[i].xa);
            check($sformatf("vec%0d_rdata_b", i), 0, rdb[0], vecs[i].xb);
            check($sformatf("vec%0d_busy_a", i), 0, WIDTH'(bza[0]), WIDTH'(vecs[i].ya));
            check($sformatf("vec%0d_busy_b", i), 0, WIDTH'(bzb[0]), WIDTH'(vecs[i].yb));
            cycle();
        end

        // Random traffic against the model in all four configurations.
        for (int n = 0; n < 10000; n++) begin
            we        = ($urandom_range(0, 1) == 1);
            waddr     = ADDR_BITS'($urandom_range(0, NREGS - 1));
            wdata     = $urandom;
            set_busy  = ($urandom_range(0, 2) == 0);
            busy_addr = ADDR_BITS'($urandom_range(0, NREGS - 1));
            raddr_a   = ($urandom_range(0, 3) == 0) ? waddr : ADDR_BITS'($urandom_range(0, NREGS - 1));
            raddr_b   = ($urandom_range(0, 3) == 0) ? raddr_a : ADDR_BITS'($urandom_range(0, NREGS - 1));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
